// File: rtl/pcmcia_spi_ctrl.sv
// ---------------------------------------------------------------------------
// pcmcia_spi_ctrl
//
// Bridges card-bus I/O cycles to a single-byte SPI master (mode 0, MSB first).
// Four 8-bit I/O registers are decoded from A[1:0]:
//   0 DATA    write: load tx and start a transfer   read: last received byte
//   1 STATUS  read-only {3'b0, collision, overrun, int_sync, rx_valid, busy}
//   2 CTRL    {DIV[3:0], spare[2:0], ss_on}; SCLK half-period = DIV+1 clocks
//   3 reserved (reads 0, writes ignored)
//
// Ports
//   clk_26          system clock
//   RESET           asynchronous, active-high reset
//   A, D_in         host register offset and write data
//   D_out, ddir     host read data and "card drives bus" flag (combinational)
//   CE1, IOWR, IORD active-low card enable and I/O strobes
//   WAIT            active-low cycle stretch
//   SS, SCLK, MOSI  SPI master outputs; MISO SPI data in
//   INT             raw slave interrupt, synchronised and shown in STATUS[2]
//
// Configuration macro: PCSPI_WAIT_EN
//   defined   : a DATA read while busy drives WAIT low until the byte lands
//   undefined : WAIT is tied high and hosts poll STATUS[0]
//
// FSM states
//   state | meaning
//   IDLE  | SCLK low; a pending start (busy=1) drives MOSI=tx[7] and enters LOW
//   LOW   | SCLK low for DIV+1 clocks, then rise and sample MISO
//   HIGH  | SCLK high for DIV+1 clocks, then fall; next bit or DONE
//   DONE  | one clock: publish rx, update rx_valid/overrun, clear busy
// ---------------------------------------------------------------------------
module pcmcia_spi_ctrl #(
    parameter logic [3:0] DIV_RESET = 4'd3,
    parameter int         SYNC_STG  = 2
) (
    input  logic       clk_26,
    input  logic       RESET,
    input  logic [1:0] A,
    input  logic [7:0] D_in,
    output logic [7:0] D_out,
    output logic       ddir,
    input  logic       CE1,
    input  logic       IOWR,
    input  logic       IORD,
    output logic       WAIT,
    output logic       SS,
    output logic       SCLK,
    output logic       MOSI,
    input  logic       MISO,
    input  logic       INT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    // synchronisers and strobe edge detection
    logic [SYNC_STG-1:0] iowr_sr, iord_sr, int_sr;
    logic                iowr_s, iord_s, int_s;
    logic                iowr_d, iord_d;
    logic                wr_rise, rd_rise;
    logic                wr_edge_q;

    always_ff @(posedge clk_26 or posedge RESET) begin
        if (RESET) begin
            iowr_sr   <= '1;
            iord_sr   <= '1;
            int_sr    <= '0;
            iowr_d    <= 1'b1;
            iord_d    <= 1'b1;
            wr_edge_q <= 1'b0;
        end else begin
            iowr_sr   <= {iowr_sr[SYNC_STG-2:0], IOWR};
            iord_sr   <= {iord_sr[SYNC_STG-2:0], IORD};
            int_sr    <= {int_sr[SYNC_STG-2:0], INT};
            iowr_d    <= iowr_s;
            iord_d    <= iord_s;
            wr_edge_q <= wr_rise;
        end
    end

    assign iowr_s  = iowr_sr[SYNC_STG-1];
    assign iord_s  = iord_sr[SYNC_STG-1];
    assign int_s   = int_sr[SYNC_STG-1];
    assign wr_rise = iowr_s & ~iowr_d;
    assign rd_rise = iord_s & ~iord_d;

    // host cycle capture: address/data are re-captured every clock of an
    // active cycle, so the values seen just before the strobe rises win
    logic [1:0] wr_a, rd_a;
    logic [7:0] wr_d;
    logic       wr_cap, rd_cap;
    logic       wr_commit, rd_clr;

    always_ff @(posedge clk_26 or posedge RESET) begin
        if (RESET) begin
            wr_a   <= 2'd0;
            wr_d   <= 8'd0;
            wr_cap <= 1'b0;
            rd_a   <= 2'd0;
            rd_cap <= 1'b0;
        end else begin
            if (!iowr_s && !CE1) begin
                wr_a   <= A;
                wr_d   <= D_in;
                wr_cap <= 1'b1;
            end else if (wr_commit) begin
                wr_cap <= 1'b0;
            end
            if (!iord_s && !CE1) begin
                rd_a   <= A;
                rd_cap <= 1'b1;
            end else if (rd_rise) begin
                rd_cap <= 1'b0;
            end
        end
    end

    // commit one clock after the synced rising edge is seen
    assign wr_commit = wr_edge_q & wr_cap;
    assign rd_clr    = rd_rise & rd_cap;

    // register file and SPI byte engine
    state_t     state;
    logic       busy;
    logic [7:0] tx;
    logic [7:0] rx;
    logic [7:0] rx_sh;
    logic       rx_valid;
    logic       overrun;
    logic       collision;
    logic [3:0] div;
    logic [2:0] ctrl_mid;
    logic       ss_on;
    logic       sclk_q;
    logic       mosi_q;
    logic [3:0] ph_cnt;
    logic [2:0] bit_cnt;

    always_ff @(posedge clk_26 or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            busy      <= 1'b0;
            tx        <= 8'd0;
            rx        <= 8'd0;
            rx_sh     <= 8'd0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            collision <= 1'b0;
            div       <= DIV_RESET;
            ctrl_mid  <= 3'd0;
            ss_on     <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ph_cnt    <= 4'd0;
            bit_cnt   <= 3'd0;
        end else begin
            // read-to-clear first; any set later in this block overrides it
            if (rd_clr && rd_a == 2'd0) begin
                rx_valid <= 1'b0;
            end
            if (rd_clr && rd_a == 2'd1) begin
                overrun   <= 1'b0;
                collision <= 1'b0;
            end

            if (wr_commit) begin
                case (wr_a)
                    2'd0: begin
                        if (busy) begin
                            collision <= 1'b1;
                        end else begin
                            tx   <= wr_d;
                            busy <= 1'b1;
                        end
                    end
                    2'd2: begin
                        div      <= wr_d[7:4];
                        ctrl_mid <= wr_d[3:1];
                        ss_on    <= wr_d[0];
                    end
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    sclk_q <= 1'b0;
                    if (busy) begin
                        mosi_q  <= tx[7];
                        ph_cnt  <= div;
                        bit_cnt <= 3'd0;
                        state   <= LOW;
                    end
                end
                LOW: begin
                    if (ph_cnt == 4'd0) begin
                        sclk_q <= 1'b1;
                        rx_sh  <= {rx_sh[6:0], MISO};
                        ph_cnt <= div;
                        state  <= HIGH;
                    end else begin
                        ph_cnt <= ph_cnt - 4'd1;
                    end
                end
                HIGH: begin
                    if (ph_cnt == 4'd0) begin
                        sclk_q <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            state <= DONE;
                        end else begin
                            tx      <= {tx[6:0], 1'b0};
                            mosi_q  <= tx[6];
                            bit_cnt <= bit_cnt + 3'd1;
                            ph_cnt  <= div;
                            state   <= LOW;
                        end
                    end else begin
                        ph_cnt <= ph_cnt - 4'd1;
                    end
                end
                DONE: begin
                    rx       <= rx_sh;
                    if (rx_valid) begin
                        overrun <= 1'b1;
                    end
                    rx_valid <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign SS   = ~ss_on;
    assign SCLK = sclk_q;
    assign MOSI = mosi_q;

    // host read path
    logic [7:0] rd_mux;

    always_comb begin
        rd_mux = 8'd0;
        case (A)
            2'd0:    rd_mux = rx;
            2'd1:    rd_mux = {3'b000, collision, overrun, int_s, rx_valid, busy};
            2'd2:    rd_mux = {div, ctrl_mid, ss_on};
            default: rd_mux = 8'd0;
        endcase
    end

    assign ddir  = ~IORD & ~CE1;
    assign D_out = ddir ? rd_mux : 8'd0;

`ifdef PCSPI_WAIT_EN
    // registered: asserts one clock into the read, releases one clock after
    // DONE so the stretched read sees the freshly published rx byte
    logic wait_q;

    always_ff @(posedge clk_26 or posedge RESET) begin
        if (RESET) begin
            wait_q <= 1'b1;
        end else begin
            wait_q <= ~(~IORD & ~CE1 & (A == 2'd0) & busy);
        end
    end

    assign WAIT = wait_q;
`else
    assign WAIT = 1'b1;
`endif

endmodule

// File: tb/tb_pcmcia_spi_ctrl.sv
`timescale 1ns/1ps
module tb_pcmcia_spi_ctrl;

    logic       clk_26 = 1'b0;
    logic       RESET  = 1'b1;
    logic [1:0] A      = 2'd0;
    logic [7:0] D_in   = 8'd0;
    logic [7:0] D_out;
    logic       ddir;
    logic       CE1    = 1'b1;
    logic       IOWR   = 1'b1;
    logic       IORD   = 1'b1;
    logic       WAIT;
    logic       SS;
    logic       SCLK;
    logic       MOSI;
    logic       MISO;
    logic       INT    = 1'b0;

    pcmcia_spi_ctrl dut (
        .clk_26 (clk_26),
        .RESET  (RESET),
        .A      (A),
        .D_in   (D_in),
        .D_out  (D_out),
        .ddir   (ddir),
        .CE1    (CE1),
        .IOWR   (IOWR),
        .IORD   (IORD),
        .WAIT   (WAIT),
        .SS     (SS),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .MISO   (MISO),
        .INT    (INT)
    );

    always #5 clk_26 = ~clk_26;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, required %02h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // SPI slave: presents MSB of its byte, shifts on each SCLK fall (mode 0)
    logic [7:0] miso_sr = 8'd0;
    assign MISO = miso_sr[7];
    always @(negedge SCLK) miso_sr = {miso_sr[6:0], 1'b0};

    // reference model: register contents as the host should see them
    logic [7:0] m_rx      = 8'd0;
    logic [7:0] m_ctrl    = 8'h30;
    logic [7:0] m_inflight = 8'd0;
    logic       m_rxv     = 1'b0;
    logic       m_ovr     = 1'b0;
    logic       m_col     = 1'b0;
    logic       m_busy    = 1'b0;

    function automatic logic [7:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_rx;
            2'd1:    return {3'b000, m_col, m_ovr, INT, m_rxv, m_busy};
            2'd2:    return m_ctrl;
            default: return 8'd0;
        endcase
    endfunction

    function automatic int m_div();
        return int'(m_ctrl[7:4]);
    endfunction

    task automatic m_complete();
        if (m_busy) begin
            m_busy = 1'b0;
            if (m_rxv) m_ovr = 1'b1;
            m_rx  = m_inflight;
            m_rxv = 1'b1;
        end
    endtask

    task automatic m_reset();
        m_rx = 8'd0; m_ctrl = 8'h30; m_rxv = 1'b0; m_ovr = 1'b0;
        m_col = 1'b0; m_busy = 1'b0;
    endtask

    // scoreboards
    typedef struct { logic [7:0] d; string name; } rd_exp_t;
    typedef struct { logic [7:0] tx; int div; } spi_exp_t;
    rd_exp_t  rd_q[$];
    spi_exp_t spi_q[$];
    logic     rd_sample = 1'b0;

    // read monitor: compares the bus value at the end of each host read
    always @(posedge rd_sample) begin
        rd_exp_t e;
        if (rd_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rd_unexpected: got read %02h, required no read pending", D_out);
        end else begin
            e = rd_q.pop_front();
            check8(e.name, D_out, e.d);
            check1({e.name, "_ddir"}, ddir, 1'b1);
        end
    end

    // SPI monitor: MOSI bits and SCLK phase lengths
    int         mon_len   = 0;
    int         mon_nbits = 0;
    logic       mon_prev  = 1'b0;
    logic [7:0] mon_sh    = 8'd0;

    always @(negedge clk_26) begin
        spi_exp_t e;
        if (RESET) begin
            mon_len = 0; mon_nbits = 0; mon_prev = 1'b0;
        end else begin
            if (!mon_prev && SCLK === 1'b1) begin
                if (spi_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL spi_unexpected: got SCLK rise, required idle bus");
                end else begin
                    if (mon_nbits > 0) checkn("sclk_low_len", mon_len, spi_q[0].div + 1);
                    check1("ss_active", SS, 1'b0);
                end
                mon_sh = {mon_sh[6:0], MOSI};
                mon_nbits++;
                mon_len = 1;
            end else if (mon_prev && SCLK === 1'b0) begin
                if (spi_q.size() > 0) begin
                    checkn("sclk_high_len", mon_len, spi_q[0].div + 1);
                    if (mon_nbits == 8) begin
                        e = spi_q.pop_front();
                        check8("mosi_byte", mon_sh, e.tx);
                    end
                end
                if (mon_nbits == 8) mon_nbits = 0;
                mon_len = 1;
            end else begin
                mon_len++;
            end
            mon_prev = (SCLK === 1'b1);
        end
    end

    // host bus cycles
    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk_26);
        A = a; D_in = d; CE1 = 1'b0; IOWR = 1'b0;
        repeat (4) @(negedge clk_26);
        IOWR = 1'b1;
        @(negedge clk_26);
        CE1 = 1'b1;
        repeat (6) @(negedge clk_26);
    endtask

    task automatic host_write(input logic [1:0] a, input logic [7:0] d, input logic [7:0] miso);
        spi_exp_t s;
        if (a == 2'd0) begin
            if (m_busy) begin
                m_col = 1'b1;
            end else begin
                m_inflight = miso;
                miso_sr    = miso;
                s.tx  = d;
                s.div = m_div();
                spi_q.push_back(s);
                m_busy = 1'b1;
            end
        end else if (a == 2'd2) begin
            m_ctrl = d;
        end
        bus_write(a, d);
    endtask

    task automatic host_read(input logic [1:0] a, input string name);
        rd_exp_t e;
        @(negedge clk_26);
        A = a; CE1 = 1'b0; IORD = 1'b0;
        repeat (4) @(negedge clk_26);
        e.d = m_read(a); e.name = name;
        rd_q.push_back(e);
        rd_sample = 1'b1; #1 rd_sample = 1'b0;
        IORD = 1'b1;
        @(negedge clk_26);
        CE1 = 1'b1;
        if (a == 2'd0) m_rxv = 1'b0;
        if (a == 2'd1) begin m_ovr = 1'b0; m_col = 1'b0; end
        repeat (5) @(negedge clk_26);
    endtask

    task automatic wait_done();
        repeat (16 * (m_div() + 1) + 6) @(negedge clk_26);
        m_complete();
    endtask

    initial begin
        // 1: reset state
        INT = 1'b1;
        repeat (3) @(negedge clk_26);
        RESET = 1'b0;
        repeat (4) @(negedge clk_26);
        check1("rst_ss", SS, 1'b1);
        check1("rst_sclk", SCLK, 1'b0);
        check1("rst_mosi", MOSI, 1'b0);
        check1("rst_wait", WAIT, 1'b1);
        check1("rst_ddir", ddir, 1'b0);
        check8("rst_dout", D_out, 8'h00);
        host_read(2'd2, "rst_ctrl");
        host_read(2'd1, "rst_status");
        host_read(2'd0, "rst_data");

        // 2: DIV=3, ss_on, A5 out / 3C in
        INT = 1'b0;
        host_write(2'd2, 8'h31, 8'h00);
        check1("ss_on", SS, 1'b0);
        host_write(2'd0, 8'hA5, 8'h3C);
        wait_done();
        host_read(2'd1, "xfer_status");
        host_read(2'd0, "xfer_data");

        // 3: collision
        host_write(2'd0, 8'h11, 8'h5A);
        host_write(2'd0, 8'h11, 8'h00);
        host_read(2'd1, "col_status");
        host_read(2'd1, "col_status_cleared");
        wait_done();
        host_read(2'd0, "col_data");

        // 4: overrun
        host_write(2'd0, 8'h81, 8'hC3);
        wait_done();
        host_write(2'd0, 8'h7E, 8'h96);
        wait_done();
        host_read(2'd1, "ovr_status");
        host_read(2'd0, "ovr_data");

        // 5: DIV=0
        host_write(2'd2, 8'h01, 8'h00);
        host_write(2'd0, 8'hFF, 8'h69);
        wait_done();
        host_read(2'd0, "div0_data");

        // 6: DATA read during a transfer
        host_write(2'd2, 8'h31, 8'h00);
        host_write(2'd0, 8'h4D, 8'hB2);
`ifdef PCSPI_WAIT_EN
        begin
            rd_exp_t e;
            int k;
            @(negedge clk_26);
            A = 2'd0; CE1 = 1'b0; IORD = 1'b0;
            repeat (2) @(negedge clk_26);
            check1("wait_asserted", WAIT, 1'b0);
            k = 0;
            while (WAIT !== 1'b1 && k < 300) begin
                @(negedge clk_26);
                k++;
            end
            check1("wait_released", (k < 300), 1'b1);
            m_complete();
            e.d = m_rx; e.name = "wait_data";
            rd_q.push_back(e);
            rd_sample = 1'b1; #1 rd_sample = 1'b0;
            IORD = 1'b1;
            @(negedge clk_26);
            CE1 = 1'b1;
            m_rxv = 1'b0;
            repeat (5) @(negedge clk_26);
        end
`else
        begin
            rd_exp_t e;
            @(negedge clk_26);
            A = 2'd0; CE1 = 1'b0; IORD = 1'b0;
            repeat (4) begin
                @(negedge clk_26);
                check1("wait_tied_high", WAIT, 1'b1);
            end
            e.d = m_rx; e.name = "nowait_old_data";
            rd_q.push_back(e);
            rd_sample = 1'b1; #1 rd_sample = 1'b0;
            IORD = 1'b1;
            @(negedge clk_26);
            CE1 = 1'b1;
            m_rxv = 1'b0;
            repeat (5) @(negedge clk_26);
            wait_done();
        end
`endif
        host_read(2'd1, "post_wait_status");

        // reset in the middle of a transfer
        host_write(2'd0, 8'hE7, 8'h18);
        repeat (20) @(negedge clk_26);
        RESET = 1'b1;
        spi_q.delete();
        m_reset();
        repeat (2) @(negedge clk_26);
        RESET = 1'b0;
        repeat (4) @(negedge clk_26);
        check1("abort_sclk", SCLK, 1'b0);
        check1("abort_ss", SS, 1'b1);
        host_read(2'd1, "abort_status");
        host_read(2'd0, "abort_data");
        host_read(2'd2, "abort_ctrl");

        // randomized transfers and register traffic
        for (int it = 0; it < 12; it++) begin
            logic [3:0] dv;
            logic [7:0] c;
            dv  = 4'($urandom_range(0, 3));
            c   = {dv, 3'($urandom), 1'b1};
            INT = 1'($urandom);
            host_write(2'd2, c, 8'h00);
            host_read(2'd2, "rnd_ctrl");
            host_write(2'd3, 8'($urandom), 8'h00);
            host_read(2'd3, "rnd_reserved");
            host_write(2'd0, 8'($urandom), 8'($urandom));
            if (dv != 4'd0 && $urandom_range(0, 1) == 1)
                host_write(2'd0, 8'($urandom), 8'h00);
            if (dv != 4'd0)
                host_read(2'd1, "rnd_busy_status");
            wait_done();
            if ($urandom_range(0, 1) == 1) host_read(2'd1, "rnd_status");
            if ($urandom_range(0, 2) != 0) host_read(2'd0, "rnd_data");
        end
        host_read(2'd1, "final_status");
        host_read(2'd0, "final_data");

        repeat (20) @(negedge clk_26);
        checkn("rd_queue_drained", rd_q.size(), 0);
        checkn("spi_queue_drained", spi_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
